input_packet_ctrl: RTL

- Avalon-MM slave controller that sequences packet-word capture from an external producer into the Nios system.
- Runs an asynchronous 4-phase req/ack handshake with the producer and buffers captured 32-bit words in a small FIFO.
- Software reads the words through a pop-on-read data register and sees status and interrupt.
- Sits between the board-level packet source and the system interconnect; a host read returns one buffered packet word.

---
 rtl/input_packet_pkg.sv | 27 ++
 rtl/input_packet_fifo.sv | 55 +++++
 rtl/input_packet_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/input_packet_pkg.sv
// Shared constants for the input packet controller: register map, bit fields, FSM encoding.
package input_packet_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_CMD     = 2'd3;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_STALL     = 2;
  localparam int unsigned ST_UNDERFLOW = 3;
  localparam int unsigned ST_LEVEL_LSB = 8;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned CMD_FLUSH     = 0;
  localparam int unsigned CMD_CLR_FLAGS = 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StAckHi   = 2'd2
  } state_e;

endpackage

// File: rtl/input_packet_fifo.sv
// Synchronous word FIFO with flush; level counter kept separately from the wrapping pointers.
module input_packet_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LVL_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      level_q <= level_q + LVL_W'(1);
      else if (do_pop && !do_push) level_q <= level_q - LVL_W'(1);
    end
  end

  // Storage needs no reset; a flushed word is never visible because level gates reads.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/input_packet_ctrl.sv
// Avalon-MM slave capturing producer words via a 4-phase req/ack handshake into a small FIFO.
module input_packet_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LVL_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_req,
  output logic              in_ack,
  output logic              irq
);

  import input_packet_pkg::*;

  logic              req_meta_q, req_s_q;
  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              enable_q, irq_en_q, underflow_q, irq_q;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [DATA_W-1:0] status_word, control_word;

  logic              rd_en, wr_en, push, pop, flush, clr_flags, ctrl_we, underflow_set, stall;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic              unused_wdata;

  assign unused_wdata = ^writedata[DATA_W-1:2];

  input_packet_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (in_data),
    .pop     (pop),
    .flush   (flush),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= in_req;
      req_s_q    <= req_meta_q;
    end
  end

  assign rd_en         = chipselect & read;
  assign wr_en         = chipselect & write;
  assign pop           = rd_en && (address == ADDR_DATA) && !fifo_empty;
  assign underflow_set = rd_en && (address == ADDR_DATA) && fifo_empty;
  assign flush         = wr_en && (address == ADDR_CMD) && writedata[CMD_FLUSH];
  assign clr_flags     = wr_en && (address == ADDR_CMD) && writedata[CMD_CLR_FLAGS];
  assign ctrl_we       = wr_en && (address == ADDR_CONTROL);
  // Only an unserved request counts as stalled; in ACK_HI the word is already taken.
  assign stall         = (state_q == StIdle) && req_s_q && fifo_full;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_q && req_s_q && !fifo_full) state_d = StCapture;
      end
      StCapture: begin
        push    = 1'b1;
        ack_d   = 1'b1;
        state_d = StAckHi;
      end
      StAckHi: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    status_word                           = '0;
    status_word[ST_NOT_EMPTY]             = ~fifo_empty;
    status_word[ST_FULL]                  = fifo_full;
    status_word[ST_STALL]                 = stall;
    status_word[ST_UNDERFLOW]             = underflow_q;
    status_word[ST_LEVEL_LSB +: LVL_W]    = fifo_level;
    control_word                          = '0;
    control_word[CTRL_ENABLE]             = enable_q;
    control_word[CTRL_IRQ_EN]             = irq_en_q;
  end

  always_comb begin
    readdata_d = '0;
    if (rd_en) begin
      unique case (address)
        ADDR_DATA:    readdata_d = fifo_empty ? '0 : fifo_head;
        ADDR_STATUS:  readdata_d = status_word;
        ADDR_CONTROL: readdata_d = control_word;
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ack_q       <= 1'b0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      underflow_q <= 1'b0;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_en_q & ~fifo_empty;
      if (ctrl_we) begin
        enable_q <= writedata[CTRL_ENABLE];
        irq_en_q <= writedata[CTRL_IRQ_EN];
      end
      // A same-cycle underflow beats CLR_FLAGS.
      if (underflow_set)  underflow_q <= 1'b1;
      else if (clr_flags) underflow_q <= 1'b0;
    end
  end

  assign readdata = readdata_q;
  assign in_ack   = ack_q;
  assign irq      = irq_q;

endmodule
